// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - BlockyRoads game-flow controller (status FSM, background scroll, score)
//
// Optional feature macro: GAME_CTRL_SPEEDUP_EN (speed level derived from score, added to scroll step)
//
// Ports:
//   clk        in   1  system clock, clocks every register
//   clr        in   1  synchronous active-low reset
//   vsync      in   1  active-low vertical sync (foreign clock domain, synchronized here)
//   btn_start  in   1  debounced start button, active-high level
//   btn_pause  in   1  debounced pause button, active-high level
//   collide    in   1  collision flag, already synchronous to clk
//   status     out  2  00 load, 01 activate, 10 pause, 11 terminate
//   scroll_y   out 10  background row offset, 0..FRAME_H-1
//   score      out 16  frames survived, saturating
//   level      out  3  speed level (0 unless speed-up is built in)
module game_ctrl #(
  parameter int SCROLL_STEP = 2,
  parameter int FRAME_H     = 360,
  parameter int TERM_HOLD   = 60
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        vsync,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        collide,
  output logic [1:0]  status,
  output logic [9:0]  scroll_y,
  output logic [15:0] score,
  output logic [2:0]  level
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_TERM   = 2'b11
  } state_t;

  localparam logic [10:0] FRAME_H_W   = 11'(FRAME_H);
  localparam logic [10:0] STEP_BASE   = 11'(SCROLL_STEP);
  localparam logic [6:0]  TERM_HOLD_W = 7'(TERM_HOLD);

  // Synchronizer chains: bit0 = s1, bit1 = s2, bit2 = s3 (history)
  logic [2:0]  vs_q, vs_d;
  logic [2:0]  st_q, st_d;
  logic [2:0]  pa_q, pa_d;

  state_t      state_q, state_d;
  logic [9:0]  scroll_q, scroll_d;
  logic [15:0] score_q, score_d;
  logic [6:0]  hold_q, hold_d;

  logic        tick, start_ev, pause_ev;
  logic        advance;
  logic [10:0] step;
  logic [10:0] scroll_sum;

  assign tick     = ~vs_q[1] & vs_q[2];
  assign start_ev =  st_q[1] & ~st_q[2];
  assign pause_ev =  pa_q[1] & ~pa_q[2];

`ifdef GAME_CTRL_SPEEDUP_EN
  logic [2:0] level_q, level_d;

  assign step  = STEP_BASE + {8'd0, level_q};
  assign level = level_q;

  // Level tracks the next score so both registers move on the same edge
  always_comb begin
    level_d = (score_d[15:11] > 5'd7) ? 3'd7 : score_d[13:11];
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      level_q <= 3'd0;
    end else begin
      level_q <= level_d;
    end
  end
`else
  assign step  = STEP_BASE;
  assign level = 3'd0;
`endif

  always_comb begin
    vs_d       = {vs_q[1:0], vsync};
    st_d       = {st_q[1:0], btn_start};
    pa_d       = {pa_q[1:0], btn_pause};
    state_d    = state_q;
    scroll_d   = scroll_q;
    score_d    = score_q;
    hold_d     = hold_q;
    advance    = 1'b0;
    scroll_sum = 11'd0;

    case (state_q)
      ST_LOAD: begin
        if (start_ev) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A colliding frame ends the game and is not scored
        if (tick && collide) begin
          state_d = ST_TERM;
          hold_d  = 7'd0;
        end else begin
          if (pause_ev) state_d = ST_PAUSE;
          advance = tick;
        end
      end
      ST_PAUSE: begin
        if (pause_ev || start_ev) state_d = ST_ACTIVE;
      end
      ST_TERM: begin
        if (tick && (hold_q < TERM_HOLD_W)) hold_d = hold_q + 7'd1;
        // Early start presses are dropped, not remembered
        if (start_ev && (hold_q == TERM_HOLD_W)) begin
          state_d  = ST_LOAD;
          scroll_d = 10'd0;
          score_d  = 16'd0;
          hold_d   = 7'd0;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    if (advance) begin
      // step < FRAME_H, so one conditional subtraction is a full modulo
      scroll_sum = {1'b0, scroll_q} + step;
      if (scroll_sum >= FRAME_H_W) scroll_sum = scroll_sum - FRAME_H_W;
      scroll_d = scroll_sum[9:0];
      if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      // vsync idles high, so its chain restores to 1 and no tick is fabricated
      vs_q     <= 3'b111;
      st_q     <= 3'b000;
      pa_q     <= 3'b000;
      state_q  <= ST_LOAD;
      scroll_q <= 10'd0;
      score_q  <= 16'd0;
      hold_q   <= 7'd0;
    end else begin
      vs_q     <= vs_d;
      st_q     <= st_d;
      pa_q     <= pa_d;
      state_q  <= state_d;
      scroll_q <= scroll_d;
      score_q  <= score_d;
      hold_q   <= hold_d;
    end
  end

  assign status   = state_q;
  assign scroll_y = scroll_q;
  assign score    = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - self-checking bench for game_ctrl
module tb_game_ctrl;

  localparam int OP_TICK       = 0;
  localparam int OP_START      = 1;
  localparam int OP_PAUSE      = 2;
  localparam int OP_TICK_PAUSE = 3;

  typedef struct {
    int          op;
    logic        coll;
    logic [1:0]  st;
    logic [9:0]  sy;
    logic [15:0] sc;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [9:0]  sy;
    logic [15:0] sc;
    logic [2:0]  lv;
  } exp_t;

  logic        clk;
  logic        clr;
  logic        vsync;
  logic        btn_start;
  logic        btn_pause;
  logic        collide;
  logic [1:0]  status;
  logic [9:0]  scroll_y;
  logic [15:0] score;
  logic [2:0]  level;

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[12];

  game_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .vsync     (vsync),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .collide   (collide),
    .status    (status),
    .scroll_y  (scroll_y),
    .score     (score),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic [1:0] st, input logic [9:0] sy,
                          input logic [15:0] sc, input logic [2:0] lv);
    exp_t e;
    e.name = nm; e.st = st; e.sy = sy; e.sc = sc; e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      cmp({e.name, ".status"},   32'(status),   32'(e.st));
      cmp({e.name, ".scroll_y"}, 32'(scroll_y), 32'(e.sy));
      cmp({e.name, ".score"},    32'(score),    32'(e.sc));
      cmp({e.name, ".level"},    32'(level),    32'(e.lv));
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Each op spans 5 cycles: edge at N0, event active after E2, registers update at E3,
  // input released at N2 and chains back to idle by E5.
  task automatic apply_op(input int op, input logic coll);
    collide = coll;
    case (op)
      OP_TICK:       vsync = 1'b0;
      OP_START:      btn_start = 1'b1;
      OP_PAUSE:      btn_pause = 1'b1;
      default: begin vsync = 1'b0; btn_pause = 1'b1; end
    endcase
    wait_n(2);
    vsync = 1'b1; btn_start = 1'b0; btn_pause = 1'b0;
    wait_n(3);
    collide = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) apply_op(OP_TICK, 1'b0);
  endtask

  task automatic do_reset();
    clr = 1'b0; vsync = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; collide = 1'b0;
    wait_n(2);
    clr = 1'b1;
    wait_n(1);
  endtask

  int     trans;
  logic [1:0] prev_st;

  initial begin
    checks = 0;
    failures = 0;
    clr = 1'b0; vsync = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; collide = 1'b0;

    vecs[0]  = '{OP_TICK,       1'b0, 2'd0, 10'd0, 16'd0};
    vecs[1]  = '{OP_PAUSE,      1'b0, 2'd0, 10'd0, 16'd0};
    vecs[2]  = '{OP_START,      1'b0, 2'd1, 10'd0, 16'd0};
    vecs[3]  = '{OP_TICK,       1'b0, 2'd1, 10'd2, 16'd1};
    vecs[4]  = '{OP_TICK,       1'b0, 2'd1, 10'd4, 16'd2};
    vecs[5]  = '{OP_PAUSE,      1'b0, 2'd2, 10'd4, 16'd2};
    vecs[6]  = '{OP_TICK,       1'b0, 2'd2, 10'd4, 16'd2};
    vecs[7]  = '{OP_PAUSE,      1'b0, 2'd1, 10'd4, 16'd2};
    vecs[8]  = '{OP_TICK_PAUSE, 1'b0, 2'd2, 10'd6, 16'd3};
    vecs[9]  = '{OP_START,      1'b0, 2'd1, 10'd6, 16'd3};
    vecs[10] = '{OP_TICK,       1'b1, 2'd3, 10'd6, 16'd3};
    vecs[11] = '{OP_START,      1'b0, 2'd3, 10'd6, 16'd3};

    @(negedge clk);
    do_reset();
    push_exp("reset", 2'd0, 10'd0, 16'd0, 3'd0);
    pop_check();

    for (int i = 0; i < 12; i++) begin
      push_exp($sformatf("vec%0d", i), vecs[i].st, vecs[i].sy, vecs[i].sc, 3'd0);
      apply_op(vecs[i].op, vecs[i].coll);
      pop_check();
    end

    // Start latency: status flips exactly 3 cycles after the rise, once
    do_reset();
    btn_start = 1'b1;
    trans = 0;
    prev_st = status;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) cmp("start_lat_e2", 32'(status), 32'd0);
      if (i == 3) cmp("start_lat_e3", 32'(status), 32'd1);
      if (status != prev_st) trans++;
      prev_st = status;
      if (i == 5) btn_start = 1'b0;
    end
    cmp("start_one_transition", 32'(trans), 32'd1);

    // Scroll wrap at FRAME_H
    ticks(179);
    push_exp("wrap_pre", 2'd1, 10'd358, 16'd179, 3'd0);
    pop_check();
    apply_op(OP_TICK, 1'b0);
    push_exp("wrap", 2'd1, 10'd0, 16'd180, 3'd0);
    pop_check();

    // Collision outranks pause on the same tick
    do_reset();
    apply_op(OP_START, 1'b0);
    ticks(2);
    push_exp("collide_prio", 2'd3, 10'd4, 16'd2, 3'd0);
    apply_op(OP_TICK_PAUSE, 1'b1);
    pop_check();

    // Terminate hold: start only honoured once 60 ticks have passed
    ticks(10);
    push_exp("term_10", 2'd3, 10'd4, 16'd2, 3'd0);
    apply_op(OP_START, 1'b0);
    pop_check();
    ticks(49);
    push_exp("term_59", 2'd3, 10'd4, 16'd2, 3'd0);
    apply_op(OP_START, 1'b0);
    pop_check();
    ticks(1);
    push_exp("term_60", 2'd0, 10'd0, 16'd0, 3'd0);
    apply_op(OP_START, 1'b0);
    pop_check();
    push_exp("restart", 2'd1, 10'd0, 16'd0, 3'd0);
    apply_op(OP_START, 1'b0);
    pop_check();

    // Pause freeze
    do_reset();
    apply_op(OP_START, 1'b0);
    ticks(3);
    push_exp("pause_enter", 2'd2, 10'd6, 16'd3, 3'd0);
    apply_op(OP_PAUSE, 1'b0);
    pop_check();
    ticks(20);
    push_exp("pause_frozen", 2'd2, 10'd6, 16'd3, 3'd0);
    pop_check();
    push_exp("pause_resume", 2'd1, 10'd6, 16'd3, 3'd0);
    apply_op(OP_START, 1'b0);
    pop_check();

    // Speed-up boundary at score 2048 (2047 ticks * 2 rows = 4094 mod 360 = 134)
    do_reset();
    apply_op(OP_START, 1'b0);
    ticks(2047);
    push_exp("spd_2047", 2'd1, 10'd134, 16'd2047, 3'd0);
    pop_check();
`ifdef GAME_CTRL_SPEEDUP_EN
    push_exp("spd_2048", 2'd1, 10'd136, 16'd2048, 3'd1);
    apply_op(OP_TICK, 1'b0);
    pop_check();
    push_exp("spd_step3", 2'd1, 10'd139, 16'd2049, 3'd1);
    apply_op(OP_TICK, 1'b0);
    pop_check();
`else
    push_exp("spd_2048", 2'd1, 10'd136, 16'd2048, 3'd0);
    apply_op(OP_TICK, 1'b0);
    pop_check();
    push_exp("spd_step2", 2'd1, 10'd138, 16'd2049, 3'd0);
    apply_op(OP_TICK, 1'b0);
    pop_check();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-flow controller for BlockyRoads; sequences the `status` code consumed by `Renderer`. Tracks:
- **Status:** load / activate / pause / terminate, driven by player buttons and collision.
- **Background scroll:** a wrapping vertical offset advanced once per video frame.
- **Score:** a saturating frame count.

It sits between the board inputs and `Renderer` and runs on the 100 MHz system clock. Frame timing comes from the `vsync` pulse of `vga_sync`.

## Interface
Parameters:
- `SCROLL_STEP`, default 2: rows added to `scroll_y` per active frame.
- `FRAME_H`, default 360: background height; `scroll_y` wraps modulo this value.
- `TERM_HOLD`, default 60: frames spent in terminate before start is accepted.

Ports:
- `clk`, in, 1: system clock. Every register in the block is clocked by it.
- `clr`, in, 1: reset, synchronous, active-low.
- `vsync`, in, 1: active-low vertical sync from `vga_sync` (25 MHz domain).
- `btn_start`, in, 1: debounced start button, active-high level.
- `btn_pause`, in, 1: debounced pause button, active-high level.
- `collide`, in, 1: collision flag, synchronous to `clk`, active-high level.
- `status`, out, 2: load=00, activate=01, pause=10, terminate=11.
- `scroll_y`, out, 10: background row offset, range 0..`FRAME_H`-1.
- `score`, out, 16: frames survived, saturates at 16'hFFFF.
- `level`, out, 3: speed level (see Configuration).

## Operation
Input conditioning:
- `vsync`, `btn_start` and `btn_pause` each pass through a 2-flop synchronizer (s1, s2), then a history flop (s3).
- Event pulses are combinational from the flops:
  - `tick` = ~s2 & s3 (vsync falling edge).
  - `start_ev` = s2 & ~s3 (start rising edge).
  - `pause_ev` = s2 & ~s3 (pause rising edge).
- A button held high gives exactly one event.

State machine (register `status`):
- **load:** `start_ev` moves to activate.
- **activate:**
  - `tick` & `collide` moves to terminate.
  - Otherwise `pause_ev` moves to pause.
  - Collision outranks pause when both occur in the same cycle.
- **pause:** `pause_ev` or `start_ev` moves to activate.
- **terminate:**
  - `hold_cnt` (7 bits) increments on each `tick` and saturates at `TERM_HOLD`.
  - `start_ev` with `hold_cnt` == `TERM_HOLD` moves to load.
  - `start_ev` earlier is ignored and not queued.
- Entering load clears `score`, `scroll_y` and `hold_cnt` on the same edge.
- Entering terminate clears `hold_cnt`.

Datapath (updates only on a `tick` in activate that does not cause terminate):
- **Scroll:** sum = `scroll_y` + step.
  - If sum ≥ `FRAME_H`, `scroll_y` takes sum − `FRAME_H`; otherwise it takes sum.
  - Step is always < `FRAME_H`, so a single subtraction suffices.
- **Score:** `score` increments by 1; it holds at FFFF with no wrap.
- Pause, load and terminate freeze `scroll_y` and `score`.

## Timing
- Reset: `clr`=0 sampled on a `clk` edge gives:
  - `status`=00 (load), `scroll_y`=0, `score`=0, `level`=0, `hold_cnt`=0.
  - All synchronizer flops: vsync flops = 1 (idle high); button flops = 0.
- Reset mid-game behaves identically; no event is generated from the restored idle values.
- Latency from an input edge (meeting setup before clk edge E1) to register update:
  - Pulse is active in the cycle after E2.
  - `status`, `scroll_y` and `score` update at E3, i.e. 3 cycles.
- `collide` is sampled unsynchronized, in the same cycle as `tick`.
- All outputs are registered; there are no combinational input→output paths.
- A button event and a `tick` in the same cycle in activate:
  - `pause_ev` moves to pause.
  - The `tick` still updates scroll and score, unless `collide` is high.

## Configuration
- Macro: `GAME_CTRL_SPEEDUP_EN`.
- **Defined:**
  - `level` = min(`score`[15:11], 7).
  - step = `SCROLL_STEP` + `level`.
  - `level` is registered and updated with `score`.
- **Undefined:**
  - `level` is tied to 0.
  - step = `SCROLL_STEP`.
  - No speed-up logic is synthesized.
- Parameters must satisfy `SCROLL_STEP` + 7 < `FRAME_H` when the macro is defined.

## Test plan
- **Reset and start:** reset, then pulse `btn_start` high for 5 cycles.
  - `status` goes 00→01 exactly 3 cycles after the rise.
  - Exactly one transition occurs.
- **Scroll wrap:** default parameters, activate, `scroll_y` preset to 358 via 179 ticks.
  - Next `tick` gives `scroll_y`=0.
  - `score`=180.
- **Collision priority:** activate with `collide`=1 and `btn_pause` rising so that `tick` and `pause_ev` coincide.
  - `status`=11.
  - `score` and `scroll_y` unchanged.
- **Terminate hold:** in terminate, `btn_start` after 10 ticks stays at 11.
  - After 60 ticks, `btn_start` gives `status`=00, `score`=0, `scroll_y`=0.
- **Pause freeze:** pause during activate, then 20 ticks.
  - `score` and `scroll_y` constant.
  - `btn_start` returns `status` to 01.
- **Speed-up:** with `GAME_CTRL_SPEEDUP_EN`, force `score` to 2047.
  - Next tick gives `score`=2048 and `level`=1.
  - The following tick advances `scroll_y` by 3.
  - Without the macro it advances by 2 and `level`=0.
